// File: rtl/tl_sink_id_pool.sv
// Shared sink ID pool for TileLink L2 adapter requesters.
//
// Serves NUM_REQ requesters from one pool of 2^ID_W sink IDs. Requesters are
// arbitrated round-robin, with one allocation per cycle. The ID is returned in
// the handshake cycle. Per-ID metadata is stored when an ID is granted, so that
// it can be looked up when the E-channel GrantAck arrives.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   alloc_valid     per-requester allocation request
//   alloc_meta      per-requester metadata (slice i = requester i)
//   alloc_ready     one-hot grant
//   alloc_id        ID handed to the granted requester this cycle
//   dealloc_valid   release request
//   dealloc_id      ID being released
//   meta_rd_id      metadata lookup address
//   meta_rd_data    combinational metadata read
//   free_count      registered number of free IDs
//   pool_empty      free_count == 0
//   err_dealloc     registered pulse on release of a free ID
//
// Optional feature macro: TL_SINK_ID_POOL_ERR_CHK_EN
//   When the macro is defined, a release of a free ID is flagged on err_dealloc
//   and is otherwise ignored.
//   When the macro is not defined, err_dealloc is tied low and every release
//   clears its bit.
module tl_sink_id_pool #(
    parameter int unsigned ID_W    = 3,
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned META_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        alloc_valid,
    input  logic [NUM_REQ*META_W-1:0] alloc_meta,
    output logic [NUM_REQ-1:0]        alloc_ready,
    output logic [ID_W-1:0]           alloc_id,
    input  logic                      dealloc_valid,
    input  logic [ID_W-1:0]           dealloc_id,
    input  logic [ID_W-1:0]           meta_rd_id,
    output logic [META_W-1:0]         meta_rd_data,
    output logic [ID_W:0]             free_count,
    output logic                      pool_empty,
    output logic                      err_dealloc
);

    localparam int unsigned NUM_IDS = 1 << ID_W;
    localparam int unsigned ARB_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_IDS-1:0] in_use_q, in_use_d;
    logic [META_W-1:0]  meta_q [NUM_IDS];
    logic [ID_W-1:0]    id_ptr_q, id_ptr_d;
    logic [ARB_W-1:0]   arb_ptr_q, arb_ptr_d;
    logic [ID_W:0]      free_count_q, free_count_d;
    logic               err_q, err_d;

    logic [ID_W-1:0]    id_probe;
    logic [ARB_W-1:0]   req_probe;
    logic [ARB_W-1:0]   cand_idx;
    logic               grant;
    logic               dealloc_legal;
    logic [META_W-1:0]  grant_meta;

    // Circular first-free search starting at id_ptr. The loop runs downward, so
    // the last write (the smallest offset) wins.
    always_comb begin
        alloc_id = id_ptr_q;
        id_probe = '0;
        for (int i = NUM_IDS - 1; i >= 0; i--) begin
            id_probe = id_ptr_q + ID_W'(i);
            if (!in_use_q[id_probe]) begin
                alloc_id = id_probe;
            end
        end
    end

    // Round-robin candidate: the first valid requester at or after arb_ptr.
    always_comb begin
        cand_idx  = '0;
        req_probe = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            req_probe = ARB_W'((int'(arb_ptr_q) + i) % NUM_REQ);
            if (alloc_valid[req_probe]) begin
                cand_idx = req_probe;
            end
        end
    end

    // Grant is masked during reset so that no handshake is seen while state is cleared.
    always_comb begin
        alloc_ready = '0;
        if (!rst && (|alloc_valid) && (free_count_q != '0)) begin
            alloc_ready[cand_idx] = 1'b1;
        end
    end

    assign grant         = |alloc_ready;
    assign grant_meta    = alloc_meta[int'(cand_idx)*META_W +: META_W];
    assign dealloc_legal = dealloc_valid && in_use_q[dealloc_id];

    always_comb begin
        in_use_d     = in_use_q;
        free_count_d = free_count_q;
        id_ptr_d     = id_ptr_q;
        arb_ptr_d    = arb_ptr_q;
        err_d        = 1'b0;

`ifdef TL_SINK_ID_POOL_ERR_CHK_EN
        if (dealloc_legal) begin
            in_use_d[dealloc_id] = 1'b0;
        end
        err_d = dealloc_valid && !in_use_q[dealloc_id];
`else
        if (dealloc_valid) begin
            in_use_d[dealloc_id] = 1'b0;
        end
`endif

        // The allocation is applied after the release. A release that targets
        // the ID being allocated (which is necessarily free) therefore cannot
        // undo the allocation.
        if (grant) begin
            in_use_d[alloc_id] = 1'b1;
            id_ptr_d           = alloc_id + ID_W'(1);
            arb_ptr_d          = (cand_idx == ARB_W'(NUM_REQ - 1)) ? '0 : cand_idx + ARB_W'(1);
        end

        // The count only rises for a release of an ID that was actually in use.
        unique case ({grant, dealloc_legal})
            2'b10:   free_count_d = free_count_q - (ID_W+1)'(1);
            2'b01:   free_count_d = free_count_q + (ID_W+1)'(1);
            default: free_count_d = free_count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_use_q     <= '0;
            free_count_q <= (ID_W+1)'(NUM_IDS);
            id_ptr_q     <= '0;
            arb_ptr_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            in_use_q     <= in_use_d;
            free_count_q <= free_count_d;
            id_ptr_q     <= id_ptr_d;
            arb_ptr_q    <= arb_ptr_d;
            err_q        <= err_d;
        end
    end

    // Metadata is not reset: its contents only matter while the ID is in use.
    always_ff @(posedge clk) begin
        if (grant) begin
            meta_q[alloc_id] <= grant_meta;
        end
    end

    assign meta_rd_data = meta_q[meta_rd_id];
    assign free_count   = free_count_q;
    assign pool_empty   = (free_count_q == '0);
    assign err_dealloc  = err_q;

endmodule

// File: tb/tb_tl_sink_id_pool.sv
// Self-checking bench for tl_sink_id_pool (ID_W=3, NUM_REQ=2, META_W=8).
// Directed table vectors are followed by hand-written corner sequences and a
// randomized phase that is checked against a reference model of the pool.
module tb_tl_sink_id_pool;

`ifdef TL_SINK_ID_POOL_ERR_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  alloc_valid;
    logic [15:0] alloc_meta;
    logic [1:0]  alloc_ready;
    logic [2:0]  alloc_id;
    logic        dealloc_valid;
    logic [2:0]  dealloc_id;
    logic [2:0]  meta_rd_id;
    logic [7:0]  meta_rd_data;
    logic [3:0]  free_count;
    logic        pool_empty;
    logic        err_dealloc;

    int passes = 0;
    int total  = 0;

    tl_sink_id_pool #(
        .ID_W    (3),
        .NUM_REQ (2),
        .META_W  (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_valid   (alloc_valid),
        .alloc_meta    (alloc_meta),
        .alloc_ready   (alloc_ready),
        .alloc_id      (alloc_id),
        .dealloc_valid (dealloc_valid),
        .dealloc_id    (dealloc_id),
        .meta_rd_id    (meta_rd_id),
        .meta_rd_data  (meta_rd_data),
        .free_count    (free_count),
        .pool_empty    (pool_empty),
        .err_dealloc   (err_dealloc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: the set of IDs in use, plus the two search pointers.
    bit         m_used [8];
    logic [7:0] m_meta [8];
    int         m_ptr;
    int         m_arb;
    bit         m_err;

    function automatic int m_free();
        int n = 0;
        for (int i = 0; i < 8; i++) if (!m_used[i]) n++;
        return n;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_used[i] = 1'b0;
        m_ptr = 0;
        m_arb = 0;
        m_err = 1'b0;
    endtask

    task automatic m_predict(input logic [1:0] v, output logic [1:0] rdy,
                             output int id, output int cand);
        rdy  = 2'b00;
        id   = -1;
        cand = -1;
        for (int i = 0; i < 8; i++) if (id < 0 && !m_used[(m_ptr + i) % 8]) id = (m_ptr + i) % 8;
        for (int i = 0; i < 2; i++) if (cand < 0 && v[(m_arb + i) % 2]) cand = (m_arb + i) % 2;
        if (cand >= 0 && m_free() > 0) rdy[cand] = 1'b1;
    endtask

    task automatic m_commit(input logic [1:0] v, input logic [15:0] meta,
                            input logic dv, input logic [2:0] did);
        logic [1:0] rdy;
        int id, cand;
        m_predict(v, rdy, id, cand);
        m_err = 1'b0;
        if (dv) begin
            if (m_used[did]) m_used[did] = 1'b0;
            else m_err = ERR_EN;
        end
        if (rdy != 2'b00) begin
            m_used[id] = 1'b1;
            m_meta[id] = (cand == 1) ? meta[15:8] : meta[7:0];
            m_ptr = (id + 1) % 8;
            m_arb = (cand + 1) % 2;
        end
    endtask

    task automatic do_reset(input bit chk);
        rst = 1'b1;
        alloc_valid = 2'b11;
        dealloc_valid = 1'b0;
        dealloc_id = '0;
        alloc_meta = '0;
        meta_rd_id = '0;
        #1;
        if (chk) begin
            check("reset_ready", alloc_ready, 0);
            check("reset_free", free_count, 8);
            check("reset_empty", pool_empty, 0);
            check("reset_err", err_dealloc, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        alloc_valid = 2'b00;
        m_reset();
    endtask

    typedef struct {
        logic [1:0] v;
        logic       dv;
        logic [2:0] did;
        logic [1:0] rdy;
        logic [2:0] id;
        bit         chk_id;
        int         free_after;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] v, input logic dv, input logic [2:0] did,
                       input logic [1:0] rdy, input logic [2:0] id, input bit chk_id,
                       input int fa);
        vec_t t;
        t.v = v; t.dv = dv; t.did = did; t.rdy = rdy; t.id = id;
        t.chk_id = chk_id; t.free_after = fa;
        vecs.push_back(t);
    endtask

    task automatic rand_cycle();
        logic [1:0]  v, rdy;
        logic        dv;
        logic [2:0]  did;
        logic [15:0] meta;
        int id, cand;
        int used_q[$];
        for (int i = 0; i < 8; i++) if (m_used[i]) used_q.push_back(i);
        v    = 2'($urandom_range(0, 3));
        dv   = ($urandom_range(0, 1) == 0);
        meta = 16'($urandom);
        if ($urandom_range(0, 3) != 0 && used_q.size() > 0)
            did = 3'(used_q[$urandom_range(0, used_q.size() - 1)]);
        else
            did = 3'($urandom_range(0, 7));
        alloc_valid = v;
        alloc_meta = meta;
        dealloc_valid = dv;
        dealloc_id = did;
        meta_rd_id = 3'($urandom_range(0, 7));
        #2;
        m_predict(v, rdy, id, cand);
        check("rand_ready", alloc_ready, rdy);
        if (rdy != 2'b00) check("rand_id", alloc_id, id);
        if (m_used[meta_rd_id]) check("rand_meta", meta_rd_data, m_meta[meta_rd_id]);
        check("rand_free", free_count, m_free());
        check("rand_empty", pool_empty, m_free() == 0);
        @(posedge clk);
        m_commit(v, meta, dv, did);
        #1;
        check("rand_err", err_dealloc, m_err);
    endtask

    initial begin
        logic [7:0] ma, mb;
        rst = 1'b1;
        alloc_valid = '0;
        alloc_meta = '0;
        dealloc_valid = 1'b0;
        dealloc_id = '0;
        meta_rd_id = '0;

        // The pool fills from reset, then frees 5 while full, then wraps,
        // then does a simultaneous alloc and dealloc.
        for (int i = 0; i < 8; i++) add(2'b01, 0, 0, 2'b01, 3'(i), 1, 7 - i);
        add(2'b01, 0, 0, 2'b00, 0, 0, 0);
        add(2'b01, 1, 5, 2'b00, 0, 0, 1);
        add(2'b01, 0, 0, 2'b01, 5, 1, 0);
        add(2'b00, 1, 1, 2'b00, 0, 0, 1);
        add(2'b10, 0, 0, 2'b10, 1, 1, 0);
        add(2'b00, 1, 0, 2'b00, 0, 0, 1);
        add(2'b00, 1, 2, 2'b00, 0, 0, 2);
        add(2'b00, 1, 3, 2'b00, 0, 0, 3);
        add(2'b00, 1, 4, 2'b00, 0, 0, 4);
        add(2'b01, 1, 7, 2'b01, 2, 1, 4);
        add(2'b11, 0, 0, 2'b10, 3, 1, 3);
        add(2'b11, 0, 0, 2'b01, 4, 1, 2);
        add(2'b11, 0, 0, 2'b10, 7, 1, 1);
        add(2'b11, 0, 0, 2'b01, 0, 1, 0);
        add(2'b11, 0, 0, 2'b00, 0, 0, 0);

        do_reset(1'b1);
        foreach (vecs[k]) begin
            alloc_valid = vecs[k].v;
            dealloc_valid = vecs[k].dv;
            dealloc_id = vecs[k].did;
            alloc_meta = 16'($urandom);
            #2;
            check($sformatf("vec%0d_ready", k), alloc_ready, vecs[k].rdy);
            if (vecs[k].chk_id) check($sformatf("vec%0d_id", k), alloc_id, vecs[k].id);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_free", k), free_count, vecs[k].free_after);
            check($sformatf("vec%0d_empty", k), pool_empty, vecs[k].free_after == 0);
        end

        // A release of a free ID is flagged only when error checking is built in.
        do_reset(1'b0);
        dealloc_valid = 1'b1;
        dealloc_id = 3'd3;
        @(posedge clk);
        #1;
        dealloc_valid = 1'b0;
        check("err_pulse", err_dealloc, ERR_EN);
        check("err_free", free_count, 8);
        @(posedge clk);
        #1;
        check("err_clear", err_dealloc, 0);

        // With both requesters active, grants alternate and metadata follows the winner.
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) begin
            ma = 8'(8'hA0 + i);
            mb = 8'(8'hB0 + i);
            alloc_valid = 2'b11;
            alloc_meta = {mb, ma};
            #2;
            check($sformatf("alt%0d_ready", i), alloc_ready, (i % 2 == 0) ? 1 : 2);
            check($sformatf("alt%0d_id", i), alloc_id, i);
            @(posedge clk);
            #1;
            meta_rd_id = 3'(i);
            #1;
            check($sformatf("alt%0d_meta", i), meta_rd_data, (i % 2 == 0) ? ma : mb);
        end

        // A reset during traffic frees everything immediately.
        alloc_valid = 2'b11;
        rst = 1'b1;
        #1;
        check("midrst_free", free_count, 8);
        check("midrst_ready", alloc_ready, 0);
        check("midrst_empty", pool_empty, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();

        for (int n = 0; n < 400; n++) rand_cycle();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
